// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU op codes, divider state encoding and width default
package alu_pkg;

  localparam int ALU_XLEN = 32;

  localparam logic [5:0] ALU_DIV  = 6'b001100;
  localparam logic [5:0] ALU_DIVU = 6'b001101;
  localparam logic [5:0] ALU_REM  = 6'b001110;
  localparam logic [5:0] ALU_REMU = 6'b001111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } div_state_t;

  // Every divide-family op shares the 6'b0011?? prefix
  function automatic logic is_div_sel(input logic [5:0] sel);
    return sel[5:2] == 4'b0011;
  endfunction

endpackage

// File: rtl/alu_div_step.sv
// rtl/alu_div_step.sv - one combinational radix-2 restoring division iteration
module alu_div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] partial_rem,
  input  logic [XLEN-1:0] divisor,
  input  logic            dividend_bit,
  output logic [XLEN-1:0] next_rem,
  output logic            quotient_bit
);

  logic [XLEN:0] shifted;

  // Remainder stays below the divisor, so the post-subtract value fits XLEN bits
  assign shifted      = {partial_rem, dividend_bit};
  assign quotient_bit = shifted >= {1'b0, divisor};
  assign next_rem     = quotient_bit ? (shifted[XLEN-1:0] - divisor) : shifted[XLEN-1:0];

endmodule

// File: rtl/alu_div_seq.sv
// rtl/alu_div_seq.sv - multi-cycle RV32M DIV/DIVU/REM/REMU unit with START/BUSY/DONE handshake
module alu_div_seq
  import alu_pkg::*;
#(
  parameter int XLEN  = ALU_XLEN,
  parameter int CNT_W = 5
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            START,
  input  logic [5:0]      SELECT,
  input  logic [XLEN-1:0] DATA1,
  input  logic [XLEN-1:0] DATA2,
  output logic            BUSY,
  output logic            DONE,
  output logic [XLEN-1:0] RESULT
);

  div_state_t      state, state_next;
  logic [CNT_W-1:0] cnt;
  logic [1:0]      op;
  logic            neg_quo, neg_rem, special;
  logic [XLEN-1:0] quo, rem, divisor;
  logic [XLEN-1:0] step_rem, result_q;
  logic            step_bit, done_q;
  logic            accept, is_signed, sign1, sign2, div_zero, overflow;

  assign is_signed = ~SELECT[0];
  assign accept    = START && (state == IDLE) && is_div_sel(SELECT);
  assign sign1     = is_signed & DATA1[XLEN-1];
  assign sign2     = is_signed & DATA2[XLEN-1];
  assign div_zero  = (DATA2 == '0);
  assign overflow  = is_signed && (DATA1 == {1'b1, {(XLEN-1){1'b0}}}) && (DATA2 == '1);

  alu_div_step #(.XLEN(XLEN)) u_step (
    .partial_rem (rem),
    .divisor     (divisor),
    .dividend_bit(quo[XLEN-1]),
    .next_rem    (step_rem),
    .quotient_bit(step_bit)
  );

  always_ff @(posedge CLK) begin
    if (!RESET) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = (div_zero || overflow) ? FIX : CALC;
      CALC:    if (&cnt) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // quo doubles as the dividend shift register: dividend bits leave at the top
  // while quotient bits enter at the bottom.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      cnt     <= '0;
      op      <= '0;
      neg_quo <= 1'b0;
      neg_rem <= 1'b0;
      special <= 1'b0;
      quo     <= '0;
      rem     <= '0;
      divisor <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          cnt     <= '0;
          op      <= SELECT[1:0];
          neg_quo <= sign1 ^ sign2;
          neg_rem <= sign1;
          special <= div_zero | overflow;
          divisor <= sign2 ? -DATA2 : DATA2;
          if (div_zero) begin
            quo <= '1;
            rem <= DATA1;
          end else if (overflow) begin
            quo <= {1'b1, {(XLEN-1){1'b0}}};
            rem <= '0;
          end else begin
            quo <= sign1 ? -DATA1 : DATA1;
            rem <= '0;
          end
        end
        CALC: begin
          cnt <= cnt + 1'b1;
          quo <= {quo[XLEN-2:0], step_bit};
          rem <= step_rem;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      done_q <= (state == FIX);
      if (state == FIX) begin
        if (special)     result_q <= op[1] ? rem : quo;
        else if (op[1])  result_q <= neg_rem ? -rem : rem;
        else             result_q <= neg_quo ? -quo : quo;
      end
    end
  end

  assign BUSY   = (state != IDLE);
  assign DONE   = done_q;
  assign RESULT = result_q;

endmodule

// File: doc/alu_div_seq.md
Name: alu_div_seq

Overview:
- Multi-cycle iterative divide/remainder unit for the RV32M DIV, DIVU, REM and REMU operations.
- It answers the ALU's single-cycle divide path: operands and op code are issued with a START/BUSY/DONE handshake, which removes the long combinational divider from the EX stage critical path.
- It sits beside alu in the EX stage, sharing the DATA1/DATA2/SELECT encoding. The pipeline stalls on BUSY.

Parameters:
- XLEN, 32, operand/result width. Only 32 is verified.
- CNT_W, 5, iteration counter width; must satisfy 2**CNT_W == XLEN.

Ports:
- CLK  input  1  clock, rising edge.
- RESET  input  1  synchronous, active-low reset.
- START  input  1  request strobe, sampled on the rising edge.
- SELECT  input  6  op code: 6'b001100 DIV, 6'b001101 DIVU, 6'b001110 REM, 6'b001111 REMU.
- DATA1  input  XLEN  dividend.
- DATA2  input  XLEN  divisor.
- BUSY  output  1  operation in progress.
- DONE  output  1  one-cycle pulse: RESULT is valid.
- RESULT  output  XLEN  quotient or remainder. Held until the next completion.

Behaviour:
- Reset (RESET==0 at an edge):
  - state=IDLE; BUSY=0, DONE=0, RESULT=0.
  - Clears counter and internal registers.
  - Aborts any in-flight operation with no DONE. Reset takes priority over START.
- States and transitions:
  - IDLE -> CALC, or IDLE -> FIX for special cases.
  - CALC -> FIX after 32 iterations.
  - FIX -> IDLE.
- START acceptance:
  - Accepted only in IDLE, including the cycle in which DONE is high, so back-to-back operations are allowed.
  - START in CALC/FIX is ignored; operands are not re-latched.
  - START with SELECT not matching 6'b0011?? is ignored: no BUSY, no DONE, RESULT unchanged.
- On accept, latch:
  - op code.
  - sign flags: signed ops only, taken from bit 31 of DATA1 and DATA2.
  - absolute values of DATA1/DATA2 for signed ops, raw values for unsigned ops.
- Special-case detection on accept (go directly to FIX):
  - Divide by zero (DATA2==0): quotient=32'hFFFFFFFF, remainder=DATA1 unmodified. Applies to signed and unsigned ops.
  - Signed overflow (DIV/REM, DATA1==32'h80000000, DATA2==32'hFFFFFFFF): quotient=32'h80000000, remainder=0.
- CALC:
  - Radix-2 restoring division, one step per cycle, MSB first.
  - Partial remainder is XLEN+1 bits. Shift in the next dividend bit, trial-subtract the divisor, and if non-negative keep the difference and set the quotient bit.
  - Counter counts 0..31; exits to FIX on the edge where the counter==31 step is done.
- FIX:
  - Quotient is negated if the signs differ (DIV only).
  - Remainder takes the dividend's sign (REM only).
  - RESULT is written with the quotient (DIV/DIVU) or remainder (REM/REMU), or with the special-case value.
  - DONE=1 for exactly one cycle.
- Timing, counting the START cycle as cycle 0:
  - Normal: BUSY=1 in cycles 1..33; DONE=1 and the new RESULT in cycle 34.
  - Special case: BUSY=1 in cycle 1; DONE in cycle 2.
  - BUSY and DONE are never high together.
- Invariants:
  - Operand inputs may change after the accept edge without affecting the result.
  - RESULT changes only on the FIX edge or on reset.

Decomposition:
- Package alu_pkg holds:
  - SELECT localparams shared with alu: ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU.
  - State encoding: IDLE=2'd0, CALC=2'd1, FIX=2'd2.
  - XLEN default.
- One sub-module, alu_div_step: a combinational single restoring iteration. Inputs are the partial remainder, divisor and next dividend bit; outputs are the new remainder and the quotient bit. The FSM, registers and sign fix-up stay in alu_div_seq.

Test Plan:
- DIVU, DATA1=100, DATA2=7, START in cycle 0 -> BUSY in cycles 1..33; DONE in cycle 34 with RESULT=14. Then REMU with the same operands -> RESULT=2.
- DIV -7/2 (32'hFFFFFFF9, 2) -> RESULT=32'hFFFFFFFD. REM on the same operands -> 32'hFFFFFFFF. REM 7/-2 -> 1.
- DIV 5/0 -> DONE in cycle 2, RESULT=32'hFFFFFFFF. REMU 5/0 -> RESULT=5. REM 32'h80000000/32'hFFFFFFFF -> RESULT=0 in cycle 2.
- DIV 32'h80000000/32'hFFFFFFFF -> RESULT=32'h80000000 in cycle 2. DIVU 32'hFFFFFFFF/1 -> 32'hFFFFFFFF in cycle 34.
- START with new operands in cycle 10 of a DIVU 100/7 -> ignored; RESULT=14 in cycle 34. START in the DONE cycle -> accepted, and the next DONE comes 34 cycles later.
- RESET=0 in cycle 15 of an operation -> BUSY=0, RESULT=0 on the next cycle; no DONE follows. START with SELECT=6'b000000 -> no BUSY.
